// File: rtl/sdl_video_pipe.sv
// sdl_video_pipe: raster timing generator plus output pipeline.
// The counters produce renderer coordinates. The matching enable/sync/eof sideband is
// delayed to line up with the renderer's fixed latency. A final register stage pairs that
// sideband with the returned colour, which is widened to the display depth.
module sdl_video_pipe #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 72,
  parameter int   H_BP     = 128,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 22,
  parameter int   H_W      = 11,
  parameter int   V_W      = 10,
  parameter logic SYNC_POL = 1'b1,
  parameter int   REND_LAT = 0,
  parameter int   IN_CW    = 4,
  parameter int   OUT_CW   = 8,
  parameter int   FRM_W    = 16
) (
  input  logic              pixel_clk,
  input  logic              sim_rst,
  input  logic              run,
  output logic [H_W-1:0]    h_coord,
  output logic [V_W-1:0]    v_coord,
  input  logic [IN_CW-1:0]  red,
  input  logic [IN_CW-1:0]  green,
  input  logic [IN_CW-1:0]  blue,
  output logic [H_W-1:0]    sdl_sx,
  output logic [V_W-1:0]    sdl_sy,
  output logic              sdl_de,
  output logic [OUT_CW-1:0] sdl_r,
  output logic [OUT_CW-1:0] sdl_g,
  output logic [OUT_CW-1:0] sdl_b,
  output logic              h_sync,
  output logic              v_sync,
  output logic              eof,
  output logic [FRM_W-1:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_C = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END  = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] H_ONE   = H_W'(1);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_C = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END  = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_ONE   = V_W'(1);
  localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

  // Sideband bundle, MSB first: {x, y, de, hs (polarity applied), vs (polarity applied), eof}
  localparam int SB_W = H_W + V_W + 4;
  localparam logic [SB_W-1:0] SB_RST = {{(H_W + V_W + 1){1'b0}}, ~SYNC_POL, ~SYNC_POL, 1'b0};

  // MSB-first bit replication of a channel up to the display depth, truncated
  function automatic logic [OUT_CW-1:0] widen(input logic [IN_CW-1:0] c);
    logic [OUT_CW-1:0] w;
    w = '0;
    for (int i = 0; i < OUT_CW; i++) begin
      w[OUT_CW-1-i] = c[IN_CW-1-(i % IN_CW)];
    end
    return w;
  endfunction

  logic [H_W-1:0]  h_cnt_r;
  logic [V_W-1:0]  v_cnt_r;
  logic            de_raw_s;
  logic            hs_raw_s;
  logic            vs_raw_s;
  logic            eof_raw_s;
  logic [SB_W-1:0] sb_raw_s;
  logic [SB_W-1:0] sb_al_s;
  logic [H_W-1:0]  al_x_s;
  logic [V_W-1:0]  al_y_s;
  logic            al_de_s;
  logic            al_hs_s;
  logic            al_vs_s;
  logic            al_eof_s;

  // Raster counters: h wraps per line, v advances on each h wrap; both freeze while run is low
  always_ff @(posedge pixel_clk or posedge sim_rst) begin
    if (sim_rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (run) begin
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= '0;
        if (v_cnt_r == V_LAST) begin
          v_cnt_r <= '0;
        end else begin
          v_cnt_r <= v_cnt_r + V_ONE;
        end
      end else begin
        h_cnt_r <= h_cnt_r + H_ONE;
      end
    end
  end

  assign h_coord = h_cnt_r;
  assign v_coord = v_cnt_r;

  // Raw enable/sync/eof decode. eof is gated by run so a frozen last pixel never re-fires.
  always_comb begin
    de_raw_s  = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
    hs_raw_s  = (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
    vs_raw_s  = (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
    eof_raw_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST) && run;
    sb_raw_s  = {h_cnt_r, v_cnt_r, de_raw_s,
                 (hs_raw_s ? SYNC_POL : ~SYNC_POL),
                 (vs_raw_s ? SYNC_POL : ~SYNC_POL),
                 eof_raw_s};
  end

  generate
    if (REND_LAT == 0) begin : g_nodelay
      assign sb_al_s = sb_raw_s;
    end else begin : g_delay
      logic [SB_W-1:0] pipe_r [REND_LAT];

      // Alignment delay line; always shifts so issued coordinates drain while run is low
      always_ff @(posedge pixel_clk or posedge sim_rst) begin
        if (sim_rst) begin
          for (int i = 0; i < REND_LAT; i++) begin
            pipe_r[i] <= SB_RST;
          end
        end else begin
          pipe_r[0] <= sb_raw_s;
          for (int i = 1; i < REND_LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign sb_al_s = pipe_r[REND_LAT-1];
    end
  endgenerate

  assign al_x_s   = sb_al_s[SB_W-1 -: H_W];
  assign al_y_s   = sb_al_s[SB_W-H_W-1 -: V_W];
  assign al_de_s  = sb_al_s[3];
  assign al_hs_s  = sb_al_s[2];
  assign al_vs_s  = sb_al_s[1];
  assign al_eof_s = sb_al_s[0];

  // Output register: pairs aligned sideband with this cycle's colour, blanks outside the active area
  always_ff @(posedge pixel_clk or posedge sim_rst) begin
    if (sim_rst) begin
      sdl_sx    <= '0;
      sdl_sy    <= '0;
      sdl_de    <= 1'b0;
      sdl_r     <= '0;
      sdl_g     <= '0;
      sdl_b     <= '0;
      h_sync    <= ~SYNC_POL;
      v_sync    <= ~SYNC_POL;
      eof       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sdl_sx <= al_x_s;
      sdl_sy <= al_y_s;
      sdl_de <= al_de_s;
      sdl_r  <= al_de_s ? widen(red)   : '0;
      sdl_g  <= al_de_s ? widen(green) : '0;
      sdl_b  <= al_de_s ? widen(blue)  : '0;
      h_sync <= al_hs_s;
      v_sync <= al_vs_s;
      eof    <= al_eof_s;
      if (al_eof_s) begin
        frame_cnt <= frame_cnt + FRM_ONE;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: doc/sdl_video_pipe.md
# sdl_video_pipe

Parametrised video timing generator and output pipeline for the simulation and board tops. It generates pixel coordinates, display enable and sync for a configurable mode, and takes colour from a renderer with a fixed, known latency. It re-aligns coordinates and enable with that colour, widens the colour to the display depth, and emits registered SDL/VGA-style outputs plus frame-level status. It replaces the ad-hoc pairing of a fixed timing controller with a hand-written output register stage.

## Interface
Parameters:
- H_ACTIVE, 800: visible pixels per line
- H_FP, 24 / H_SYNC, 72 / H_BP, 128: horizontal front porch, sync and back porch, in pixels
- V_ACTIVE, 600: visible lines
- V_FP, 1 / V_SYNC, 2 / V_BP, 22: vertical front porch, sync and back porch, in lines
- H_W, 11 / V_W, 10: coordinate widths; must hold H_TOTAL-1 and V_TOTAL-1
- SYNC_POL, 1: active level of h_sync and v_sync
- REND_LAT, 0: renderer latency in cycles, from coordinate out to colour in, range 0..7
- IN_CW, 4 / OUT_CW, 8: input and output colour bits per channel, IN_CW ≤ OUT_CW
- FRM_W, 16: frame counter width

Ports:
- pixel_clk  in  1  pixel clock
- sim_rst  in  1  reset, asynchronous, active-high
- run  in  1  counters advance when 1 and hold when 0
- h_coord  out  H_W  current horizontal count, fed to the renderer
- v_coord  out  V_W  current vertical count, fed to the renderer
- red, green, blue  in  IN_CW each  renderer colour, valid REND_LAT cycles after its coordinate
- sdl_sx  out  H_W  aligned horizontal coordinate
- sdl_sy  out  V_W  aligned vertical coordinate
- sdl_de  out  1  aligned display enable
- sdl_r, sdl_g, sdl_b  out  OUT_CW each  aligned, widened colour
- h_sync, v_sync  out  1  aligned sync outputs
- eof  out  1  one-cycle pulse on the aligned last pixel of a frame
- frame_cnt  out  FRM_W  completed frames, wrapping

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, i.e. 1024. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, i.e. 625.
- Counter stage:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - On the h wrap, v_cnt increments. v_cnt wraps 0 after V_TOTAL-1.
  - When run=0, both counters hold.
  - h_coord = h_cnt and v_coord = v_cnt, driven combinationally from the registers.
- Raw enable and sync are derived from the counts:
  - de_raw = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs_raw is active for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs_raw is active for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC
  - eof_raw = (h_cnt == H_TOTAL-1) && (v_cnt == V_TOTAL-1) && run
- Alignment:
  - Coordinates, de_raw, hs_raw, vs_raw and eof_raw pass through a REND_LAT-deep shift register.
  - The shift register always shifts, independent of run.
  - With REND_LAT=0 there is no delay stage.
- Output register: one final stage captures the aligned sideband and the colour together.
- Colour widening:
  - Replicate the input MSB-first to OUT_CW bits and truncate.
  - Examples: 4→8 maps 0xA to 0xAA; 5→8 maps c to {c, c[4:2]}.
  - When sdl_de would be 0, sdl_r, sdl_g and sdl_b are forced to 0.
- frame_cnt increments on the same cycle eof is asserted, and wraps at 2^FRM_W.
- Sync outputs drive SYNC_POL while active and ~SYNC_POL otherwise.

## Timing
- Reset values:
  - h_cnt, v_cnt and every pipeline stage are 0.
  - sdl_* outputs and eof are 0. frame_cnt is 0.
  - h_sync and v_sync are at ~SYNC_POL.
  - Pipeline stages hold inactive sync, not zero.
- Reset mid-frame: all state returns asynchronously to the reset values, and counting restarts at (0,0) on the first clock after release.
- Latency: from h_coord/v_coord = (x,y) to sdl_sx/sdl_sy = (x,y) is REND_LAT+1 cycles. The colour sampled in that final cycle is paired with (x,y).
- Wrap: (H_TOTAL-1, y) is followed by (0, y+1). (H_TOTAL-1, V_TOTAL-1) is followed by (0,0).
- run deasserted: the counters freeze, and the pipeline drains the previously issued coordinates over REND_LAT+1 cycles. Stale values are not repeated as new eof pulses.
- Simultaneous run falling edge and the eof position: eof_raw requires run=1 on the cycle the counter is at the last pixel.

## Test plan
- Reset values: assert sim_rst mid-line with SYNC_POL=1 → all outputs 0, h_sync=v_sync=0, frame_cnt=0. On release, h_coord steps 0,1,2 on successive cycles.
- Line and frame wrap, defaults, run=1 → h_coord 1023→0 with v_coord +1. After 640000 cycles: eof is high for exactly one cycle with sdl_sx=1023, sdl_sy=624, and frame_cnt=1.
- Sync and enable windows → sdl_de=1 for x<800 and y<600. h_sync active for sdl_sx 824..895, v_sync active for sdl_sy 601..602. Repeat with SYNC_POL=0 and the polarity inverts.
- Latency alignment with REND_LAT=3 and the renderer returning red = h_coord[3:0] delayed 3 cycles → every active pixel shows sdl_r = {sdl_sx[3:0], sdl_sx[3:0]}.
- Widening and blanking with IN_CW=5, OUT_CW=8:
  - red=5'b10110 in the active area → sdl_r=8'b10110101
  - the same input during blanking → sdl_r=0
- run hold: deassert run for 100 cycles at (10,5) → h_coord/v_coord stay at (10,5), no eof, and counting resumes at 11.
